risc8_data_arb: RTL and testbench
=================================

Name: risc8_data_arb

Overview:
- Two-requester arbiter for the single-port synchronous data RAM/IO bus of the risc8 SoC.
- Requester 0 is the risc8 core's data port. Requester 1 is a secondary master such as a DMA engine or debug loader.
- Combinationally grants one requester per cycle, muxes its address, write data and strobes onto the RAM bus, and returns read-valid one cycle later to the owner.
- Supports bus locking for multi-cycle bursts by requester 1.

Parameters:
- ADDR_BITS, 16, width of all address buses.
- STARVE_LIMIT, 8, consecutive denied cycles after which requester 1 wins; legal range 1..255. Used only with RISC8_ARB_FAIR_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 access request.
- m0_wen  in  1  1=write, 0=read; valid with m0_req.
- m0_addr  in  ADDR_BITS  requester 0 address.
- m0_wdata  in  8  requester 0 write data.
- m0_gnt  out  1  requester 0 owns the bus this cycle.
- m0_rvalid  out  1  read data for requester 0 valid this cycle.
- m0_rdata  out  8  read data to requester 0.
- m1_req, m1_wen, m1_addr, m1_wdata  in  1/1/ADDR_BITS/8  same meaning for requester 1.
- m1_lock  in  1  keep ownership after this granted access.
- m1_gnt, m1_rvalid, m1_rdata  out  1/1/8  same meaning for requester 1.
- ram_addr  out  ADDR_BITS  address to RAM/IO decoder.
- ram_wdata  out  8  write data to RAM/IO decoder.
- ram_wen  out  1  write strobe.
- ram_ren  out  1  read strobe.
- ram_rdata  in  8  RAM/IO read data, registered by the RAM, valid one cycle after ram_ren.

Behaviour:
- Registered state:
  - lock state: OPEN or LOCKED.
  - rd_owner_v and rd_owner: pending read tag.
  - starve_cnt: 8 bits, feature only.
- Reset low (asynchronous):
  - State forced to OPEN; rd_owner_v, m0_rvalid, m1_rvalid and starve_cnt cleared to 0.
  - m0_gnt, m1_gnt, ram_wen and ram_ren are forced to 0 while reset is low.
  - A read in flight when reset asserts is discarded; no rvalid is produced for it.
- Grant is combinational from the req inputs and registered state. Zero latency: a request with no competition is granted in the same cycle.
- Grant priority, first match wins:
  - (a) state LOCKED and m1_req: grant m1.
  - (b) starve condition (feature only): grant m1.
  - (c) m0_req: grant m0.
  - (d) m1_req: grant m1.
  - (e) otherwise: no grant.
- While LOCKED, m0 is always denied. If m1_req is 0 while LOCKED, nothing is granted and the state returns to OPEN at the next edge.
- Lock transitions:
  - OPEN to LOCKED: at the edge ending a cycle where m1 was granted with m1_lock=1.
  - LOCKED to OPEN: at the edge ending a cycle where m1 was granted with m1_lock=0, or where m1_req=0.
- Bus mux:
  - ram_addr/ram_wdata come from the granted requester; from m0 when nothing is granted.
  - ram_wen = grant & wen of owner.
  - ram_ren = grant & ~wen of owner.
  - The wen input of a non-granted requester is ignored.
- Read return:
  - On a granted read, rd_owner is captured at the edge.
  - In the next cycle, exactly one of m0_rvalid/m1_rvalid is 1, for one cycle.
  - m0_rdata = m1_rdata = ram_rdata at all times; rvalid qualifies the data.
- Back-to-back reads by alternating owners are legal. Each rvalid goes to the owner of the read issued in the preceding cycle.
- Writes produce no rvalid.
- A denied requester must hold req, wen, addr and wdata stable until granted. The arbiter does not queue requests.
- Throughput: one access per cycle. No bubble is inserted on an ownership change.

Optional Feature:
- Macro: RISC8_ARB_FAIR_EN.
- With the macro:
  - starve_cnt increments (saturating at 255) each cycle m1_req=1 and m1_gnt=0.
  - starve_cnt clears on any cycle m1_gnt=1, or when m1_req=0.
  - Starve condition = starve_cnt >= STARVE_LIMIT. It overrides m0 for exactly one grant.
- Without the macro:
  - No counter exists; rule (b) is absent.
  - m0 has strict priority except while LOCKED, so m1 may starve indefinitely.

Test Plan:
- Reset: hold reset=0 with both req=1 -> m0_gnt=0, m1_gnt=0, ram_ren=0, ram_wen=0; release -> m0_gnt=1 in the same cycle.
- m0 alone reads 0x0123, RAM holds 0x5A there -> same cycle: m0_gnt=1, ram_ren=1, ram_addr=0x0123; next cycle: m0_rvalid=1, m0_rdata=0x5A, m1_rvalid=0.
- Contention: m0 reads 0x0010 while m1 writes 0x0200=0xA5 -> m0 granted and m1 waits. When m0_req drops, m1_gnt=1, ram_wen=1, ram_addr=0x0200, ram_wdata=0xA5.
- Lock burst: m1 writes 0x0300 with lock=1, then 0x0301 with lock=1, then 0x0302 with lock=0; m0_req held from cycle 2 -> m0_gnt=0 for all three m1 cycles, m0_gnt=1 in the cycle after 0x0302.
- Fairness (macro on, STARVE_LIMIT=4): both reqs held continuously -> m0 granted cycles 1-4, m1 granted cycle 5, m0 granted cycle 6. With the macro off -> m1 never granted.
- Reset mid-read: m1 read granted, reset pulsed low before the next edge -> no m1_rvalid afterwards; state OPEN; next m0 request granted immediately.

Source files
------------

// File: rtl/risc8_data_arb.sv
// rtl/risc8_data_arb.sv - two-requester arbiter for the risc8 data RAM/IO bus
//
// Build option: define RISC8_ARB_FAIR_EN to add the requester-1 starvation counter.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   m0_req/wen/addr/wdata       requester 0 (core data port) access request
//   m0_gnt/rvalid/rdata         requester 0 grant and read return
//   m1_req/wen/addr/wdata/lock  requester 1 (DMA/debug) access request, burst lock
//   m1_gnt/rvalid/rdata         requester 1 grant and read return
//   ram_addr/wdata/wen/ren      muxed bus toward the RAM/IO decoder
//   ram_rdata                   RAM read data, one cycle after ram_ren
module risc8_data_arb #(
  parameter int ADDR_BITS    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_wen,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [7:0]           m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [7:0]           m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_wen,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [7:0]           m1_wdata,
  input  logic                 m1_lock,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [7:0]           m1_rdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_wen,
  output logic                 ram_ren,
  input  logic [7:0]           ram_rdata
);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

  lock_state_t state;
  logic        rd_owner_v;
  logic        rd_owner;     // 1 = pending read belongs to requester 1
  logic        starve;
  logic        gnt0;
  logic        gnt1;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("risc8_data_arb: STARVE_LIMIT must be in 1..255");
  end

`ifdef RISC8_ARB_FAIR_EN
  logic [7:0] starve_cnt;

  assign starve = (starve_cnt >= 8'(STARVE_LIMIT));

  // Counts cycles requester 1 has been waiting; any grant or a dropped
  // request restarts the count, so a forced grant happens only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 8'd0;
    end else if (!m1_req || gnt1) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Zero-latency grant. Grants are held off while reset is low so no
  // strobe reaches the RAM during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (state == ST_LOCKED) begin
        gnt1 = m1_req;           // requester 0 is shut out for the whole burst
      end else if (starve && m1_req) begin
        gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = m1_req;
      end
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;

  // Idle bus parks on requester 0 so the core's address is already present.
  assign ram_addr  = gnt1 ? m1_addr  : m0_addr;
  assign ram_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign ram_wen   = (gnt0 & m0_wen)  | (gnt1 & m1_wen);
  assign ram_ren   = (gnt0 & ~m0_wen) | (gnt1 & ~m1_wen);

  assign m0_rvalid = rd_owner_v & ~rd_owner;
  assign m1_rvalid = rd_owner_v & rd_owner;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_OPEN;
      rd_owner_v <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (gnt1) begin
        state <= m1_lock ? ST_LOCKED : ST_OPEN;
      end else if (!m1_req) begin
        state <= ST_OPEN;
      end
      // Tag the read issued this cycle so its data returns to the right owner.
      rd_owner_v <= ram_ren;
      rd_owner   <= gnt1;
    end
  end

endmodule

// File: tb/tb_risc8_data_arb.sv
// tb/tb_risc8_data_arb.sv - self-checking bench for risc8_data_arb
module tb_risc8_data_arb;
  localparam int AB    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wen, m0_gnt, m0_rvalid;
  logic [AB-1:0] m0_addr;
  logic [7:0]    m0_wdata, m0_rdata;
  logic          m1_req, m1_wen, m1_lock, m1_gnt, m1_rvalid;
  logic [AB-1:0] m1_addr;
  logic [7:0]    m1_wdata, m1_rdata;
  logic [AB-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;
  logic          ram_wen, ram_ren;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_mem [0:65535];
  logic [7:0] mdl_mem [0:65535];

  // reference model state
  bit         mdl_locked;
  int         mdl_wait;
  bit         pend_v;
  bit         pend_owner;
  logic [7:0] pend_data;
  bit         exp_g0, exp_g1;
  bit         obs0, obs1;

  always #5 clk = ~clk;

  risc8_data_arb #(.ADDR_BITS(AB), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_ren(ram_ren),
    .ram_rdata(ram_rdata)
  );

  // registered-read RAM behind the bus
  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
    if (ram_ren) ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_expect();
    bit starve;
    starve = 1'b0;
`ifdef RISC8_ARB_FAIR_EN
    starve = (mdl_wait >= LIMIT);
`endif
    exp_g0 = 1'b0;
    exp_g1 = 1'b0;
    if (reset) begin
      if (mdl_locked)             exp_g1 = m1_req;
      else if (m1_req && starve)  exp_g1 = 1'b1;
      else if (m0_req)            exp_g0 = 1'b1;
      else if (m1_req)            exp_g1 = 1'b1;
    end
  endtask

  task automatic model_update();
    if (!reset) begin
      mdl_locked = 1'b0;
      mdl_wait   = 0;
      pend_v     = 1'b0;
      return;
    end
    pend_v     = (exp_g0 && !m0_wen) || (exp_g1 && !m1_wen);
    pend_owner = exp_g1;
    if (pend_v) pend_data = exp_g1 ? mdl_mem[m1_addr] : mdl_mem[m0_addr];
    if (exp_g0 && m0_wen) mdl_mem[m0_addr] = m0_wdata;
    if (exp_g1 && m1_wen) mdl_mem[m1_addr] = m1_wdata;
    if (exp_g1)       mdl_locked = m1_lock;
    else if (!m1_req) mdl_locked = 1'b0;
    if (m1_req && !exp_g1) mdl_wait = (mdl_wait < 255) ? mdl_wait + 1 : 255;
    else                   mdl_wait = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic tick(input bit rst_before_edge);
    bit ren_e, wen_e;
    #4;
    model_expect();
    ren_e = (exp_g0 && !m0_wen) || (exp_g1 && !m1_wen);
    wen_e = (exp_g0 && m0_wen)  || (exp_g1 && m1_wen);
    chk("m0_gnt",    32'(m0_gnt),    32'(exp_g0));
    chk("m1_gnt",    32'(m1_gnt),    32'(exp_g1));
    chk("ram_ren",   32'(ram_ren),   32'(ren_e));
    chk("ram_wen",   32'(ram_wen),   32'(wen_e));
    chk("ram_addr",  32'(ram_addr),  32'(exp_g1 ? m1_addr : m0_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(exp_g1 ? m1_wdata : m0_wdata));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(pend_v && !pend_owner));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(pend_v && pend_owner));
    if (pend_v) begin
      chk("m0_rdata", 32'(m0_rdata), 32'(pend_data));
      chk("m1_rdata", 32'(m1_rdata), 32'(pend_data));
    end
    obs0 = m0_gnt;
    obs1 = m1_gnt;
    if (rst_before_edge) begin
      #2;
      reset = 1'b0;
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_m0(input bit r, input bit w, input logic [AB-1:0] a, input logic [7:0] d);
    m0_req = r; m0_wen = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input bit r, input bit w, input logic [AB-1:0] a, input logic [7:0] d,
                        input bit l);
    m1_req = r; m1_wen = w; m1_addr = a; m1_wdata = d; m1_lock = l;
  endtask

  initial begin
    logic [3:0] lvec;
    logic [5:0] fvec;
    logic [5:0] fexp;

    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] <= 8'(i ^ (i >> 8) ^ 8'h3C);
      mdl_mem[i] =  8'(i ^ (i >> 8) ^ 8'h3C);
    end
    ram_mem[16'h0123] <= 8'h5A;
    mdl_mem[16'h0123] =  8'h5A;
    mdl_locked = 1'b0; mdl_wait = 0; pend_v = 1'b0; pend_owner = 1'b0; pend_data = 8'h00;

    reset = 1'b0;
    set_m0(1'b1, 1'b0, 16'h0001, 8'h00);
    set_m1(1'b1, 1'b0, 16'h0002, 8'h00, 1'b0);
    @(posedge clk); #1;

    // reset held with both requesting: nothing granted
    for (int i = 0; i < 3; i++) tick(1'b0);
    reset = 1'b1;
    #1 chk("rst_release_m0_gnt", 32'(m0_gnt), 32'd1);
    tick(1'b0);

    // m0 alone reads 0x0123
    set_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    set_m0(1'b1, 1'b0, 16'h0123, 8'h00);
    tick(1'b0);
    set_m0(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("rd_0123_valid", 32'(m0_rvalid), 32'd1);
    chk("rd_0123_data",  32'(m0_rdata),  32'h5A);
    tick(1'b0);

    // contention: m0 read vs m1 write, m1 waits then writes
    set_m0(1'b1, 1'b0, 16'h0010, 8'h00);
    set_m1(1'b1, 1'b1, 16'h0200, 8'hA5, 1'b0);
    tick(1'b0);
    set_m0(1'b0, 1'b0, 16'h0010, 8'h00);
    #1 chk("cont_m1_gnt", 32'(m1_gnt), 32'd1);
    tick(1'b0);
    set_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    set_m0(1'b1, 1'b0, 16'h0200, 8'h00);
    tick(1'b0);
    set_m0(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("cont_readback", 32'(m0_rdata), 32'hA5);
    tick(1'b0);

    // lock burst 0x0300..0x0302, m0 requesting from cycle 2
    for (int i = 0; i < 4; i++) begin
      set_m1(i < 3, 1'b1, 16'h0300 + 16'(i), 8'h10 + 8'(i), i < 2);
      set_m0(i >= 1, 1'b0, 16'h0040, 8'h00);
      tick(1'b0);
      lvec[i] = obs0;
    end
    chk("lock_m0_gnt_seq", 32'(lvec), 32'h8);
    set_m0(1'b0, 1'b0, 16'h0000, 8'h00);
    tick(1'b0);

    // both requesting continuously for six cycles
    for (int i = 0; i < 6; i++) begin
      set_m0(1'b1, 1'b0, 16'h0050, 8'h00);
      set_m1(1'b1, 1'b0, 16'h0060, 8'h00, 1'b0);
      tick(1'b0);
      fvec[i] = obs1;
    end
`ifdef RISC8_ARB_FAIR_EN
    fexp = 6'b010000;
`else
    fexp = 6'b000000;
`endif
    chk("fair_m1_gnt_seq", 32'(fvec), 32'(fexp));
    set_m0(1'b0, 1'b0, 16'h0000, 8'h00);
    set_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    tick(1'b0);

    // reset during an m1 read: its data never returns
    set_m1(1'b1, 1'b0, 16'h0070, 8'h00, 1'b0);
    tick(1'b1);
    set_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    chk("rst_mid_no_rvalid", 32'(m1_rvalid), 32'd0);
    tick(1'b0);
    reset = 1'b1;
    set_m0(1'b1, 1'b0, 16'h0080, 8'h00);
    #1 chk("post_rst_m0_gnt", 32'(m0_gnt), 32'd1);
    tick(1'b0);

    // randomized traffic; denied requests are held until granted
    for (int n = 0; n < 600; n++) begin
      if (!m0_req || exp_g0) begin
        m0_req   = ($urandom_range(0, 99) < 60);
        m0_wen   = 1'($urandom_range(0, 1));
        m0_addr  = 16'($urandom_range(0, 31));
        m0_wdata = 8'($urandom);
      end
      if (!m1_req || exp_g1) begin
        m1_req   = ($urandom_range(0, 99) < 55);
        m1_wen   = 1'($urandom_range(0, 1));
        m1_addr  = 16'($urandom_range(0, 31));
        m1_wdata = 8'($urandom);
        m1_lock  = ($urandom_range(0, 99) < 30);
      end
      tick(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
